// File: rtl/hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_if
// Bundle of pipeline-side signals exchanged with the hazard controller.
//
//   Pipeline -> controller:
//     RS1D, RS2D        source registers of the instruction in D
//     RS1E, RS2E        source registers of the instruction in E
//     RDE, RDM, RDW     destination registers in E, M, W
//     REG_WRM, REG_WRW  register write enables of the instructions in M, W
//     MEM_TO_REGE       instruction in E is a load
//     BRN_TAKENE        branch/jump in E resolved taken
//     MC_START_E        instruction in E is a multi-cycle op
//   Controller -> pipeline:
//     STALL_F/D/E       hold the F/D/E pipeline registers
//     FLUSH_D/E/M       insert a bubble into the D/E/M registers
//     FWD_A, FWD_B      E operand source: 00 regfile, 01 W result, 10 M result
//     MC_BUSY, MC_DONE  multi-cycle sequence in progress / final EX cycle
//
// Modports: master = pipeline datapath, slave = hazard controller.
// -----------------------------------------------------------------------------
interface hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5
);
    logic [REG_ADDR_W-1:0] RS1D;
    logic [REG_ADDR_W-1:0] RS2D;
    logic [REG_ADDR_W-1:0] RS1E;
    logic [REG_ADDR_W-1:0] RS2E;
    logic [REG_ADDR_W-1:0] RDE;
    logic [REG_ADDR_W-1:0] RDM;
    logic [REG_ADDR_W-1:0] RDW;
    logic                  REG_WRM;
    logic                  REG_WRW;
    logic                  MEM_TO_REGE;
    logic                  BRN_TAKENE;
    logic                  MC_START_E;

    logic                  STALL_F;
    logic                  STALL_D;
    logic                  STALL_E;
    logic                  FLUSH_D;
    logic                  FLUSH_E;
    logic                  FLUSH_M;
    logic [1:0]            FWD_A;
    logic [1:0]            FWD_B;
    logic                  MC_BUSY;
    logic                  MC_DONE;

    modport master (
        output RS1D, RS2D, RS1E, RS2E, RDE, RDM, RDW,
        output REG_WRM, REG_WRW, MEM_TO_REGE, BRN_TAKENE, MC_START_E,
        input  STALL_F, STALL_D, STALL_E, FLUSH_D, FLUSH_E, FLUSH_M,
        input  FWD_A, FWD_B, MC_BUSY, MC_DONE
    );

    modport slave (
        input  RS1D, RS2D, RS1E, RS2E, RDE, RDM, RDW,
        input  REG_WRM, REG_WRW, MEM_TO_REGE, BRN_TAKENE, MC_START_E,
        output STALL_F, STALL_D, STALL_E, FLUSH_D, FLUSH_E, FLUSH_M,
        output FWD_A, FWD_B, MC_BUSY, MC_DONE
    );
endinterface

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Hazard and execute-sequencing controller for the 5-stage RISC-V pipeline.
// Resolves data hazards by forwarding from M/W, stalls on load-use, flushes
// the wrong path after a taken branch, and holds the front of the pipe while
// a multi-cycle (MUL/DIV class) op occupies EX for MC_LAT cycles.
//
// Parameters:
//   MC_LAT      total EX occupancy of a multi-cycle op, 2..16
//   REG_ADDR_W  register index width
//
// Ports:
//   CLK    clock, all state updates on the rising edge
//   RST_N  synchronous active-low reset; while low the outputs are forced to
//          "flush everything, stall nothing, no forwarding"
//   hz     hazard_ctrl_if.slave, pipeline control/status bundle
//   PERF_STALL_CNT, PERF_FLUSH_CNT  (only when HAZARD_PERF_EN is defined)
//          32-bit wrapping counts of STALL_F cycles and taken-branch flushes
//
// Build option: define HAZARD_PERF_EN to add the performance counters.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int MC_LAT     = 4,
    parameter int REG_ADDR_W = 5
) (
    input  logic        CLK,
    input  logic        RST_N,
    hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] PERF_STALL_CNT,
    output logic [31:0] PERF_FLUSH_CNT
`endif
);

    typedef enum logic {
        IDLE   = 1'b0,
        MC_RUN = 1'b1
    } state_t;

    // The start cycle itself is the first stall cycle, so the counter covers
    // the remaining MC_LAT-2 stall cycles before the MC_DONE cycle.
    localparam logic [3:0] CNT_LOAD = 4'(MC_LAT - 2);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic       stall_f, stall_d, stall_e;
    logic       flush_d, flush_e, flush_m;
    logic [1:0] fwd_a, fwd_b;
    logic       mc_busy, mc_done;
    logic       load_use;

    // M has priority over W because it holds the younger result; x0 is
    // hardwired to zero and must never be forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] rs,
        input logic [REG_ADDR_W-1:0] rdm,
        input logic [REG_ADDR_W-1:0] rdw,
        input logic                  wrm,
        input logic                  wrw
    );
        if (wrm && (rdm != '0) && (rdm == rs)) begin
            return 2'b10;
        end else if (wrw && (rdw != '0) && (rdw == rs)) begin
            return 2'b01;
        end else begin
            return 2'b00;
        end
    endfunction

    assign load_use = hz.MEM_TO_REGE && (hz.RDE != '0) &&
                      ((hz.RDE == hz.RS1D) || (hz.RDE == hz.RS2D));

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned, which would otherwise infer a latch.
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_m = 1'b0;
        mc_busy = 1'b0;
        mc_done = 1'b0;
        state_d = state_q;
        cnt_d   = cnt_q;
        fwd_a   = fwd_sel(hz.RS1E, hz.RDM, hz.RDW, hz.REG_WRM, hz.REG_WRW);
        fwd_b   = fwd_sel(hz.RS2E, hz.RDM, hz.RDW, hz.REG_WRM, hz.REG_WRW);

        if (!RST_N) begin
            // Bubble every stage while reset is held so nothing retires.
            flush_d = 1'b1;
            flush_e = 1'b1;
            flush_m = 1'b1;
            fwd_a   = 2'b00;
            fwd_b   = 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hz.MC_START_E) begin
                        // A coincident taken branch is illegal decode; the
                        // multi-cycle op wins and the branch is dropped.
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        stall_e = 1'b1;
                        flush_m = 1'b1;
                        mc_busy = 1'b1;
                        state_d = MC_RUN;
                        cnt_d   = CNT_LOAD;
                    end else if (hz.BRN_TAKENE) begin
                        // D holds a wrong-path instruction, so the branch
                        // flush beats any load-use stall on it.
                        flush_d = 1'b1;
                        flush_e = 1'b1;
                    end else if (load_use) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        flush_e = 1'b1;
                    end
                end
                MC_RUN: begin
                    // E still holds the multi-cycle op, so branch, load-use
                    // and start requests are all ignored here.
                    mc_busy = 1'b1;
                    if (cnt_q != 4'd0) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        stall_e = 1'b1;
                        flush_m = 1'b1;
                        cnt_d   = cnt_q - 4'd1;
                    end else begin
                        // Result enters M on this edge; the next op may start
                        // in the very next cycle.
                        mc_done = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples its pre-edge value regardless of statement order.
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign hz.STALL_F = stall_f;
    assign hz.STALL_D = stall_d;
    assign hz.STALL_E = stall_e;
    assign hz.FLUSH_D = flush_d;
    assign hz.FLUSH_E = flush_e;
    assign hz.FLUSH_M = flush_m;
    assign hz.FWD_A   = fwd_a;
    assign hz.FWD_B   = fwd_b;
    assign hz.MC_BUSY = mc_busy;
    assign hz.MC_DONE = mc_done;

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;
    logic        brn_flush;

    // Taken-branch flush only happens in IDLE when no multi-cycle op starts.
    assign brn_flush = (state_q == IDLE) && !hz.MC_START_E && hz.BRN_TAKENE;

    always_comb begin
        perf_stall_d = perf_stall_q + {31'd0, stall_f};
        perf_flush_d = perf_flush_q + {31'd0, brn_flush};
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            perf_stall_q <= 32'd0;
            perf_flush_q <= 32'd0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign PERF_STALL_CNT = perf_stall_q;
    assign PERF_FLUSH_CNT = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed bench for hazard_ctrl. Inputs change 1 time unit after the rising
// edge and outputs are sampled on the falling edge. A second instance with
// MC_LAT=2 covers the shortest multi-cycle sequence. Define HAZARD_PERF_EN
// to include the performance-counter scenario.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int MC_LAT = 4;

    // {STALL_F, STALL_D, STALL_E, FLUSH_D, FLUSH_E, FLUSH_M, MC_BUSY, MC_DONE}
    localparam logic [7:0] C_IDLE = 8'b000_000_00;
    localparam logic [7:0] C_RST  = 8'b000_111_00;
    localparam logic [7:0] C_LU   = 8'b110_010_00;
    localparam logic [7:0] C_BRN  = 8'b000_110_00;
    localparam logic [7:0] C_MCST = 8'b111_001_10;
    localparam logic [7:0] C_DONE = 8'b000_000_11;

    typedef struct {
        logic [4:0] rs1e;
        logic [4:0] rs2e;
        logic [4:0] rdm;
        logic [4:0] rdw;
        logic       wrm;
        logic       wrw;
        logic [1:0] exp_a;
        logic [1:0] exp_b;
    } fwd_vec_t;

    logic CLK;
    logic RST_N;
    int   n_tests;
    int   n_fail;

    hazard_ctrl_if #(.REG_ADDR_W(5)) hif ();
    hazard_ctrl_if #(.REG_ADDR_W(5)) hif2 ();

    wire [7:0] ctrl1 = {hif.STALL_F, hif.STALL_D, hif.STALL_E,
                        hif.FLUSH_D, hif.FLUSH_E, hif.FLUSH_M,
                        hif.MC_BUSY, hif.MC_DONE};
    wire [7:0] ctrl2 = {hif2.STALL_F, hif2.STALL_D, hif2.STALL_E,
                        hif2.FLUSH_D, hif2.FLUSH_E, hif2.FLUSH_M,
                        hif2.MC_BUSY, hif2.MC_DONE};

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall, perf_flush, perf_stall2, perf_flush2;
`endif

    hazard_ctrl #(.MC_LAT(MC_LAT), .REG_ADDR_W(5)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .hz    (hif)
`ifdef HAZARD_PERF_EN
        ,
        .PERF_STALL_CNT (perf_stall),
        .PERF_FLUSH_CNT (perf_flush)
`endif
    );

    hazard_ctrl #(.MC_LAT(2), .REG_ADDR_W(5)) dut2 (
        .CLK   (CLK),
        .RST_N (RST_N),
        .hz    (hif2)
`ifdef HAZARD_PERF_EN
        ,
        .PERF_STALL_CNT (perf_stall2),
        .PERF_FLUSH_CNT (perf_flush2)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Decode never issues a taken branch together with a multi-cycle start.
    always @(posedge CLK) begin
        if (RST_N) begin
            assert (!(hif.MC_START_E && hif.BRN_TAKENE))
                else $error("illegal stimulus: MC_START_E with BRN_TAKENE");
            assert (!(hif2.MC_START_E && hif2.BRN_TAKENE))
                else $error("illegal stimulus: MC_START_E with BRN_TAKENE (dut2)");
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample();
        @(negedge CLK);
    endtask

    task automatic clear_inputs();
        hif.RS1D = '0;  hif.RS2D = '0;  hif.RS1E = '0;  hif.RS2E = '0;
        hif.RDE  = '0;  hif.RDM  = '0;  hif.RDW  = '0;
        hif.REG_WRM = 1'b0; hif.REG_WRW = 1'b0; hif.MEM_TO_REGE = 1'b0;
        hif.BRN_TAKENE = 1'b0; hif.MC_START_E = 1'b0;
        hif2.RS1D = '0; hif2.RS2D = '0; hif2.RS1E = '0; hif2.RS2E = '0;
        hif2.RDE  = '0; hif2.RDM  = '0; hif2.RDW  = '0;
        hif2.REG_WRM = 1'b0; hif2.REG_WRW = 1'b0; hif2.MEM_TO_REGE = 1'b0;
        hif2.BRN_TAKENE = 1'b0; hif2.MC_START_E = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        RST_N = 1'b0;
        // Requests that would otherwise stall, flush or forward.
        hif.MC_START_E = 1'b1; hif.MEM_TO_REGE = 1'b1;
        hif.RDE = 5'd7; hif.RS1D = 5'd7;
        hif.REG_WRM = 1'b1; hif.RDM = 5'd5; hif.RS1E = 5'd5;
        sample();
        n_tests++;
        if (ctrl1 !== C_RST) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected %b", ctrl1, C_RST);
        end
        n_tests++;
        if (hif.FWD_A !== 2'b00) begin
            n_fail++; $display("FAIL reset_fwd_a: got %b expected 00", hif.FWD_A);
        end
        tick();
        tick();
        RST_N = 1'b1;
        clear_inputs();
        sample();
        n_tests++;
        if (ctrl1 !== C_IDLE) begin
            n_fail++; $display("FAIL reset_release: got %b expected %b", ctrl1, C_IDLE);
        end
        tick();
    endtask

    task automatic test_forwarding();
        fwd_vec_t tab[6];
        tab[0] = '{5'd5, 5'd0, 5'd5, 5'd5, 1'b1, 1'b1, 2'b10, 2'b00};
        tab[1] = '{5'd5, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 2'b01, 2'b00};
        tab[2] = '{5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 2'b00, 2'b00};
        tab[3] = '{5'd5, 5'd9, 5'd9, 5'd9, 1'b0, 1'b1, 2'b00, 2'b01};
        tab[4] = '{5'd9, 5'd9, 5'd9, 5'd9, 1'b1, 1'b1, 2'b10, 2'b10};
        tab[5] = '{5'd3, 5'd4, 5'd4, 5'd3, 1'b1, 1'b1, 2'b01, 2'b10};
        for (int i = 0; i < 6; i++) begin
            hif.RS1E = tab[i].rs1e; hif.RS2E = tab[i].rs2e;
            hif.RDM  = tab[i].rdm;  hif.RDW  = tab[i].rdw;
            hif.REG_WRM = tab[i].wrm; hif.REG_WRW = tab[i].wrw;
            sample();
            n_tests++;
            if (hif.FWD_A !== tab[i].exp_a) begin
                n_fail++; $display("FAIL fwd_a[%0d]: got %b expected %b", i, hif.FWD_A, tab[i].exp_a);
            end
            n_tests++;
            if (hif.FWD_B !== tab[i].exp_b) begin
                n_fail++; $display("FAIL fwd_b[%0d]: got %b expected %b", i, hif.FWD_B, tab[i].exp_b);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_load_use();
        hif.MEM_TO_REGE = 1'b1; hif.RDE = 5'd7; hif.RS2D = 5'd7; hif.RS1D = 5'd3;
        sample();
        n_tests++;
        if (ctrl1 !== C_LU) begin
            n_fail++; $display("FAIL lu_rs2: got %b expected %b", ctrl1, C_LU);
        end
        tick();
        hif.MEM_TO_REGE = 1'b0;
        sample();
        n_tests++;
        if (ctrl1 !== C_IDLE) begin
            n_fail++; $display("FAIL lu_next: got %b expected %b", ctrl1, C_IDLE);
        end
        tick();
        hif.MEM_TO_REGE = 1'b1; hif.RDE = 5'd0; hif.RS1D = 5'd0; hif.RS2D = 5'd0;
        sample();
        n_tests++;
        if (ctrl1 !== C_IDLE) begin
            n_fail++; $display("FAIL lu_x0: got %b expected %b", ctrl1, C_IDLE);
        end
        tick();
        hif.RDE = 5'd12; hif.RS1D = 5'd12;
        sample();
        n_tests++;
        if (ctrl1 !== C_LU) begin
            n_fail++; $display("FAIL lu_rs1: got %b expected %b", ctrl1, C_LU);
        end
        tick();
        clear_inputs();
    endtask

    // Two ops back-to-back; the first keeps MC_START_E high the whole time it
    // sits in E, the second is a one-cycle pulse.
    task automatic test_back_to_back();
        logic [7:0] exp;
        for (int op = 0; op < 2; op++) begin
            for (int i = 0; i < MC_LAT; i++) begin
                hif.MC_START_E = (op == 0) ? 1'b1 : (i == 0);
                exp = (i < MC_LAT - 1) ? C_MCST : C_DONE;
                sample();
                n_tests++;
                if (ctrl1 !== exp) begin
                    n_fail++; $display("FAIL mc_op%0d_cyc%0d: got %b expected %b", op, i, ctrl1, exp);
                end
                tick();
            end
        end
        clear_inputs();
        sample();
        n_tests++;
        if (ctrl1 !== C_IDLE) begin
            n_fail++; $display("FAIL mc_after: got %b expected %b", ctrl1, C_IDLE);
        end
        tick();
    endtask

    task automatic test_mc_lat2();
        hif2.MC_START_E = 1'b1;
        sample();
        n_tests++;
        if (ctrl2 !== C_MCST) begin
            n_fail++; $display("FAIL lat2_stall: got %b expected %b", ctrl2, C_MCST);
        end
        tick();
        hif2.MC_START_E = 1'b0;
        sample();
        n_tests++;
        if (ctrl2 !== C_DONE) begin
            n_fail++; $display("FAIL lat2_done: got %b expected %b", ctrl2, C_DONE);
        end
        tick();
        sample();
        n_tests++;
        if (ctrl2 !== C_IDLE) begin
            n_fail++; $display("FAIL lat2_idle: got %b expected %b", ctrl2, C_IDLE);
        end
        tick();
    endtask

    task automatic test_priority();
        logic [7:0] exp;
        hif.BRN_TAKENE = 1'b1; hif.MEM_TO_REGE = 1'b1; hif.RDE = 5'd7; hif.RS1D = 5'd7;
        sample();
        n_tests++;
        if (ctrl1 !== C_BRN) begin
            n_fail++; $display("FAIL brn_over_lu: got %b expected %b", ctrl1, C_BRN);
        end
        tick();
        clear_inputs();
        hif.MC_START_E = 1'b1;
        sample();
        tick();
        // In MC_RUN: taken branch and load-use must be ignored, forwarding not.
        hif.MC_START_E = 1'b0;
        hif.BRN_TAKENE = 1'b1; hif.MEM_TO_REGE = 1'b1; hif.RDE = 5'd7; hif.RS1D = 5'd7;
        hif.REG_WRM = 1'b1; hif.RDM = 5'd5; hif.RS1E = 5'd5;
        sample();
        n_tests++;
        if (ctrl1 !== C_MCST) begin
            n_fail++; $display("FAIL brn_in_run: got %b expected %b", ctrl1, C_MCST);
        end
        n_tests++;
        if (hif.FWD_A !== 2'b10) begin
            n_fail++; $display("FAIL fwd_in_run: got %b expected 10", hif.FWD_A);
        end
        tick();
        clear_inputs();
        for (int i = 2; i <= MC_LAT; i++) begin
            exp = (i < MC_LAT - 1) ? C_MCST : ((i == MC_LAT - 1) ? C_DONE : C_IDLE);
            sample();
            n_tests++;
            if (ctrl1 !== exp) begin
                n_fail++; $display("FAIL prio_run_cyc%0d: got %b expected %b", i, ctrl1, exp);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_op();
        hif.MC_START_E = 1'b1;
        sample();
        tick();
        hif.MC_START_E = 1'b0;
        RST_N = 1'b0;
        hif.REG_WRM = 1'b1; hif.RDM = 5'd5; hif.RS1E = 5'd5;
        sample();
        n_tests++;
        if (ctrl1 !== C_RST) begin
            n_fail++; $display("FAIL rst_mid_ctrl: got %b expected %b", ctrl1, C_RST);
        end
        n_tests++;
        if (hif.FWD_A !== 2'b00) begin
            n_fail++; $display("FAIL rst_mid_fwd: got %b expected 00", hif.FWD_A);
        end
        tick();
        RST_N = 1'b1;
        clear_inputs();
        for (int i = 0; i < 2; i++) begin
            sample();
            n_tests++;
            if (ctrl1 !== C_IDLE) begin
                n_fail++; $display("FAIL rst_mid_after%0d: got %b expected %b", i, ctrl1, C_IDLE);
            end
            tick();
        end
    endtask

`ifdef HAZARD_PERF_EN
    task automatic test_perf();
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        sample();
        n_tests++;
        if (perf_stall !== 32'd0) begin
            n_fail++; $display("FAIL perf_stall_clr: got %0d expected 0", perf_stall);
        end
        n_tests++;
        if (perf_flush !== 32'd0) begin
            n_fail++; $display("FAIL perf_flush_clr: got %0d expected 0", perf_flush);
        end
        tick();
        hif.MC_START_E = 1'b1;
        tick();
        hif.MC_START_E = 1'b0;
        for (int i = 1; i <= MC_LAT; i++) tick();
        hif.BRN_TAKENE = 1'b1;
        tick();
        hif.BRN_TAKENE = 1'b0;
        tick();
        hif.BRN_TAKENE = 1'b1;
        tick();
        hif.BRN_TAKENE = 1'b0;
        sample();
        n_tests++;
        if (perf_stall !== 32'd3) begin
            n_fail++; $display("FAIL perf_stall: got %0d expected 3", perf_stall);
        end
        n_tests++;
        if (perf_flush !== 32'd2) begin
            n_fail++; $display("FAIL perf_flush: got %0d expected 2", perf_flush);
        end
        tick();
    endtask
`endif

    initial begin
        n_tests = 0;
        n_fail  = 0;
        RST_N   = 1'b0;
        clear_inputs();
        test_reset();
        test_forwarding();
        test_load_use();
        test_back_to_back();
        test_mc_lat2();
        test_priority();
        test_reset_mid_op();
`ifdef HAZARD_PERF_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard and execute-sequencing controller for the 5-stage RISC-V core.
- Consumes decode-side control (register write enable, memory-to-register, multi-cycle-op flag, branch outcome) and register indices from the D, E, M and W stages.
- Produces stall, flush and forwarding selects.
- Sequences multi-cycle execute operations (MUL/DIV class) with an internal FSM and counter, holding the front of the pipe while they run.

Parameters:
MC_LAT, 4, total EX-stage occupancy in cycles of a multi-cycle op; legal range 2..16.
REG_ADDR_W, 5, register index width.

Ports:
CLK  in  1  clock, all state updates on rising edge
RST_N  in  1  synchronous active-low reset
RS1D, RS2D  in  REG_ADDR_W  source registers of instruction in D
RS1E, RS2E  in  REG_ADDR_W  source registers of instruction in E
RDE, RDM, RDW  in  REG_ADDR_W  destination registers in E, M, W
REG_WRM, REG_WRW  in  1  register write enable of instruction in M, W
MEM_TO_REGE  in  1  instruction in E is a load
BRN_TAKENE  in  1  branch/jump in E resolved taken
MC_START_E  in  1  instruction in E is a multi-cycle op
STALL_F, STALL_D, STALL_E  out  1  hold the F/D/E pipeline registers
FLUSH_D, FLUSH_E, FLUSH_M  out  1  insert a bubble into the D/E/M registers
FWD_A, FWD_B  out  2  operand source for E: 00 regfile, 01 W result, 10 M result
MC_BUSY  out  1  multi-cycle sequence in progress
MC_DONE  out  1  final EX cycle of a multi-cycle op

Behaviour:
- State: FSM {IDLE, MC_RUN} plus a 4-bit counter CNT.
- Reset: RST_N sampled 0 sets state IDLE and CNT 0. While RST_N=0, outputs are combinationally forced:
  - FLUSH_D=FLUSH_E=FLUSH_M=1.
  - All stalls, FWD_*, MC_BUSY and MC_DONE = 0.
- Reset mid-MC_RUN aborts the sequence. The first cycle after release is IDLE with no stall.
- Forwarding (combinational, every state; FWD_B uses the same rules with RS2E):
  - FWD_A=10 if REG_WRM & RDM!=0 & RDM==RS1E.
  - Else FWD_A=01 if REG_WRW & RDW!=0 & RDW==RS1E.
  - Else FWD_A=00.
  - M has priority over W. x0 is never forwarded.
- Load-use (IDLE only): LU = MEM_TO_REGE & RDE!=0 & (RDE==RS1D | RDE==RS2D).
  - LU gives STALL_F=STALL_D=1 and FLUSH_E=1 for exactly that cycle.
  - There is no state change.
- Branch (IDLE only): BRN_TAKENE=1 gives FLUSH_D=FLUSH_E=1 and no stalls. Branch beats load-use in the same cycle, because D holds a wrong-path instruction.
- Multi-cycle sequencing:
  - IDLE & MC_START_E: STALL_F=STALL_D=STALL_E=1, FLUSH_M=1, MC_BUSY=1. Next state is MC_RUN and CNT is loaded with MC_LAT-2.
  - MC_RUN & CNT!=0: the same stall/flush set and MC_BUSY=1; CNT decrements.
  - MC_RUN & CNT==0: no stall, MC_DONE=1, MC_BUSY=1. Next state is IDLE.
  - Net result: stalls last MC_LAT-1 cycles, EX occupancy is MC_LAT cycles, and the result enters M on the MC_DONE edge.
  - MC_START_E, BRN_TAKENE and LU are ignored in MC_RUN, because E still holds the same multi-cycle instruction.
  - MC_START_E & BRN_TAKENE in IDLE is illegal per ISA decode. If it occurs, MC takes priority and the branch is dropped; the bench asserts it never occurs.
- Back-to-back multi-cycle ops: the next op can start in the cycle after MC_DONE; there is no dead cycle.
- MC_LAT=2: exactly one stall cycle, followed directly by MC_DONE.

Optional Feature:
Macro HAZARD_PERF_EN.
- Defined: adds output ports PERF_STALL_CNT[31:0] and PERF_FLUSH_CNT[31:0].
  - PERF_STALL_CNT increments on every cycle with STALL_F=1.
  - PERF_FLUSH_CNT increments on every taken-branch flush.
  - Both counters wrap at 2^32 and clear on reset.
- Undefined: the ports and counters are absent, and the remaining behaviour is identical.

Test Plan:
1. Forwarding: RS1E=5, RDM=5, REG_WRM=1, RDW=5, REG_WRW=1 -> FWD_A=10. With RDM=0 -> FWD_A=01. With RS1E=0 and both writes to x0 -> FWD_A=00.
2. Load-use: MEM_TO_REGE=1, RDE=7, RS2D=7 -> STALL_F=STALL_D=FLUSH_E=1 for one cycle. The next cycle, with MEM_TO_REGE=0, all stalls are 0.
3. Multi-cycle, MC_LAT=4: MC_START_E pulse at cycle t -> stalls 1 at t..t+2, MC_DONE=1 at t+3, MC_BUSY=1 at t..t+3, IDLE at t+4. A second MC_START_E at t+4 repeats the pattern.
4. Priority: BRN_TAKENE=1 together with a load-use match -> FLUSH_D=FLUSH_E=1, STALL_F=0. BRN_TAKENE=1 during MC_RUN -> no flush.
5. Reset mid-op: RST_N=0 at t+1 of a multi-cycle op -> all flushes 1 and stalls 0 while low. After release the state is IDLE and MC_BUSY=0.
6. With HAZARD_PERF_EN defined: one multi-cycle op (MC_LAT=4) plus two taken branches -> PERF_STALL_CNT=3, PERF_FLUSH_CNT=2.
